uart_tx_feeder: RTL
===================

# uart_tx_feeder

Byte-stream front end for the UART transmit stage. Buffers bytes from the camera/capture side in a synchronous FIFO. Drives the UART writer's level-sensitive `WR`/`write_data`/`busy` handshake one byte at a time: raise `wr`, wait for `busy` to rise, wait for `busy` to fall, drop `wr`, then enforce a low gap. It sits directly upstream of the UART writer and absorbs producer bursts while the serial line drains at baud rate.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `GAP_CYCLES`, 4: cycles `wr` is held low between bytes; ≥ 2, since the writer's edge detector needs two low samples.
- `ARM_TIMEOUT`, 64: cycles to wait for `tx_busy` rise before retrying the same byte; ≥ 4.
- `HDR0`, 8'hA5: first sync header byte.
- `HDR1`, 8'h5A: second sync header byte.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `in_data` in 8: producer byte.
- `in_valid` in 1: producer byte present this cycle.
- `in_sof` in 1: qualifies `in_data` as the first byte of a frame; stored as FIFO bit 8.
- `in_ready` out 1: `fifo_level != DEPTH`; combinational from the level register.
- `overflow` out 1: sticky; set when `in_valid && !in_ready`; cleared only by `rst`.
- `fifo_level` out ADDR_W+1: stored entries, 0..DEPTH.
- `wr` out 1: connects to the writer's `WR`; registered.
- `tx_data` out 8: connects to the writer's `write_data`; registered, stable whenever `wr` = 1.
- `tx_busy` in 1: the writer's `busy`.
- `idle` out 1: high when state = IDLE and the FIFO is empty.

## Operation
- **FIFO:** 9-bit wide, `DEPTH` entries, with read/write pointers of width ADDR_W that wrap modulo `DEPTH`.
  - A push occurs when `in_valid && in_ready`. A dropped byte sets `overflow` and changes nothing else.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - No bypass: a byte pushed in cycle N is poppable in cycle N+1 at the earliest.
- **FSM states:** IDLE, ARM, HOLD, GAP.
  - **IDLE:** if the FIFO is non-empty, pop the head, load `tx_data`, set `wr`=1, clear the timer, go to ARM.
  - **ARM:** if `tx_busy`=1, go to HOLD. If the timer reaches `ARM_TIMEOUT`-1, set `wr`=0, set `retry`, go to GAP.
  - **HOLD:** on `tx_busy`=0, set `wr`=0 and go to GAP. `tx_data` is unchanged.
  - **GAP:** count `GAP_CYCLES` cycles with `wr`=0. Then:
    - if `retry`: clear it, set `wr`=1, re-enter ARM with the same `tx_data`, no pop;
    - else if a pending payload byte exists (header mode): load it, set `wr`=1, go to ARM;
    - else go to IDLE.
- **Ordering:** bytes are sent strictly in push order with no duplication, except for retries after a timeout.
- **`rst`:** returns everything to reset values the next edge, from any state. The FIFO is emptied, and any byte in flight is abandoned by dropping `wr`.

## Timing
- **Reset values:** `wr`=0, `tx_data`=8'h00, `fifo_level`=0, `overflow`=0, state IDLE, `idle`=1, `in_ready`=1.
- **Latency:** with the FSM in IDLE, a byte pushed at edge E produces `wr`=1 and valid `tx_data` from edge E+2.
- **`wr` low width:** `wr` falls on the edge after `tx_busy` is sampled low. It stays low for exactly `GAP_CYCLES` cycles before the next rise.
- **Writer start:** the writer's `busy` rises about 3 cycles after `wr` rises, which is well inside `ARM_TIMEOUT`.
- **Back-to-back throughput:** one byte per writer frame plus `GAP_CYCLES`+2 cycles.
- **Retry period:** a byte that never raises `tx_busy` is re-presented every `ARM_TIMEOUT`+`GAP_CYCLES` cycles, indefinitely.
- **`fifo_level`:** updates on the edge of the push or pop.

## Configuration
- **`UART_TX_FEEDER_SYNC_HDR_EN`**
  - **Defined:** when the popped entry has sof=1, send `HDR0`, then `HDR1`, then the payload byte as three full handshakes. The payload is held in a pending register and only one FIFO pop occurs. Each byte gets its own `GAP_CYCLES` gap.
  - **Undefined:** the sof bit is ignored and every popped byte is sent alone. No pending register is built.

## Test plan
- **Reset:** `rst` high for 3 cycles -> `wr`=0, `tx_data`=8'h00, `fifo_level`=0, `in_ready`=1, `idle`=1.
- **Single byte, writer model with `busy` rising 3 cycles after `wr` and lasting 20 cycles:** push 8'h3C -> `wr`=1 two edges later with `tx_data`=8'h3C; `wr` falls one cycle after `busy` falls; stays low 4 cycles; `idle`=1 afterwards.
- **Burst and full:** push 20 bytes 8'h00..8'h13 on consecutive cycles with the writer stalled -> `in_ready`=0 at level 16, `overflow`=1, dropped bytes never appear, the other 17 bytes (one popped before stall) appear on `tx_data` in order.
- **Timeout:** `tx_busy` tied low, push 8'hE7 -> `wr` pulses high for 64 cycles, low for 4, repeats with `tx_data`=8'hE7, `fifo_level`=0; release the writer model -> byte completes once.
- **Reset mid-byte:** assert `rst` during HOLD with 5 bytes queued -> next edge `wr`=0, `fifo_level`=0; no stale byte sent after release.
- **Sync header (macro defined):** push 8'h11 with `in_sof`=1, then 8'h22 -> `tx_data` sequence A5, 5A, 11, 22 over four handshakes; macro undefined -> 11, 22.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// Producer stream and UART-writer handshake bundle for uart_tx_feeder.
// slave = the feeder itself; master = the producer/writer environment.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          overflow;
  logic [ADDR_W:0] fifo_level;
  logic          wr;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          idle;

  modport slave (
    input  in_data, in_valid, in_sof, tx_busy,
    output in_ready, overflow, fifo_level, wr, tx_data, idle
  );

  modport master (
    output in_data, in_valid, in_sof, tx_busy,
    input  in_ready, overflow, fifo_level, wr, tx_data, idle
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a level-sensitive WR/busy UART writer, one byte per handshake.
// Optional sync header before sof-tagged bytes: define UART_TX_FEEDER_SYNC_HDR_EN.
module uart_tx_feeder #(
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = 4,
  parameter int          GAP_CYCLES  = 4,
  parameter int          ARM_TIMEOUT = 64,
  parameter logic [7:0]  HDR0        = 8'hA5,
  parameter logic [7:0]  HDR1        = 8'h5A
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_feeder_if.slave bus
);

  localparam int TMAX = (ARM_TIMEOUT > GAP_CYCLES) ? ARM_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HOLD, S_GAP} state_t;

  // ---------------- FIFO ----------------
  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic              overflow_q;
  logic              push, pop, fifo_empty;
  logic [8:0]        head;

  assign bus.in_ready   = (level != (ADDR_W+1)'(DEPTH));
  assign push           = bus.in_valid && bus.in_ready;
  assign fifo_empty     = (level == '0);
  assign head           = mem[rd_ptr];
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;

  // NOTE: storage has no reset; the level/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_sof, bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.in_valid && !bus.in_ready) overflow_q <= 1'b1;
    end
  end

  // ---------------- handshake FSM ----------------
  state_t          state_q, state_n;
  logic            wr_q, wr_n;
  logic [7:0]      tx_q, tx_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic            retry_q, retry_n;

`ifdef UART_TX_FEEDER_SYNC_HDR_EN
  // Payload waits here while HDR0/HDR1 go out; hdr_left counts bytes still owed.
  logic [7:0] pend_q, pend_n;
  logic [1:0] hdr_left_q, hdr_left_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 8'h00;
      hdr_left_q <= 2'd0;
    end else begin
      pend_q     <= pend_n;
      hdr_left_q <= hdr_left_n;
    end
  end
`else
  logic unused_hdr;
  assign unused_hdr = ^{HDR0, HDR1, head[8]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      tx_q    <= 8'h00;
      timer_q <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_n;
      wr_q    <= wr_n;
      tx_q    <= tx_n;
      timer_q <= timer_n;
      retry_q <= retry_n;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_n = state_q;
    wr_n    = wr_q;
    tx_n    = tx_q;
    timer_n = timer_q;
    retry_n = retry_q;
    pop     = 1'b0;
`ifdef UART_TX_FEEDER_SYNC_HDR_EN
    pend_n     = pend_q;
    hdr_left_n = hdr_left_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wr_n    = 1'b1;
          timer_n = '0;
          state_n = S_ARM;
`ifdef UART_TX_FEEDER_SYNC_HDR_EN
          if (head[8]) begin
            tx_n       = HDR0;
            pend_n     = head[7:0];
            hdr_left_n = 2'd2;
          end else begin
            tx_n = head[7:0];
          end
`else
          tx_n = head[7:0];
`endif
        end
      end
      S_ARM: begin
        if (bus.tx_busy) begin
          state_n = S_HOLD;
        end else if (timer_q == TW'(ARM_TIMEOUT - 1)) begin
          wr_n    = 1'b0;
          retry_n = 1'b1;
          timer_n = '0;
          state_n = S_GAP;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (!bus.tx_busy) begin
          wr_n    = 1'b0;
          timer_n = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_n = '0;
          if (retry_q) begin
            // Re-present the same byte; nothing is popped.
            retry_n = 1'b0;
            wr_n    = 1'b1;
            state_n = S_ARM;
          end
`ifdef UART_TX_FEEDER_SYNC_HDR_EN
          else if (hdr_left_q != 2'd0) begin
            tx_n       = (hdr_left_q == 2'd2) ? HDR1 : pend_q;
            hdr_left_n = hdr_left_q - 1'b1;
            wr_n       = 1'b1;
            state_n    = S_ARM;
          end
`endif
          else begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.wr      = wr_q;
  assign bus.tx_data = tx_q;
  assign bus.idle    = (state_q == S_IDLE) && fifo_empty;

endmodule
